alu_issue: RTL
==============

ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 clk  input  1  rising-edge clock.
REQ-002 rst_n  input  1  reset, synchronous, active-low.
REQ-003 in_valid  input  1  upstream instruction valid.
REQ-004 in_ready  output  1  block can accept instruction.
REQ-005 in_instr  input  32  RV32I instruction word.
REQ-006 in_rs1_data, in_rs2_data  input  32 each  register operands.
REQ-007 alu_op  output  3  ALU operation select: 000 ADD/SUB, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL/SRA, 110 OR, 111 AND.
REQ-008 funct7  output  1  ALU modifier: 1 = SUB or SRA.
REQ-009 operand_a, operand_b  output  32 each  ALU operands.
REQ-010 alu_data  input  32  combinational ALU result, valid in the same cycle as the operands.
REQ-011 out_valid  output  1  result valid.
REQ-012 out_ready  input  1  downstream accepts result.
REQ-013 out_rd  output  5  destination register (instr[11:7]).
REQ-014 out_result  output  32  registered result.
REQ-015 out_illegal  output  1  instruction not decodable by this block.

Function
REQ-016 FSM states: IDLE, EXEC, DONE; in_ready = (IDLE) or (DONE and out_ready).
REQ-017 Accept on in_valid&in_ready: latch decoded alu_op, funct7, operand_a, operand_b, rd, illegal into registers; next state EXEC.
REQ-018 EXEC lasts exactly one cycle; at its end, alu_data is captured into out_result; next state DONE.
REQ-019 DONE: out_valid=1; on out_ready: go to EXEC if a new instruction is accepted in the same cycle, else IDLE; without out_ready hold all outputs stable.
REQ-020 Latency: accept in cycle N -> out_valid in cycle N+2; peak throughput one instruction per 2 cycles.
REQ-021 OP (opcode 0110011): operand_a=rs1, operand_b=rs2, alu_op=funct3, funct7=instr[30].
REQ-022 OP-IMM (0010011): operand_a=rs1, operand_b=sign-extended instr[31:20]; funct3 001/101 use zero-extended instr[24:20]; funct7=instr[30] only for funct3=101, else 0.
REQ-023 Illegal: any other opcode; OP with instr[31:25] not 0000000/0100000, or 0100000 with funct3 not 000/101; OP-IMM shift with instr[31:25] not 0000000 (SLLI/SRLI) or 0100000 (SRAI).
REQ-024 Illegal instruction still completes the full handshake with out_illegal=1, out_result=0.
REQ-025 rd=0 forces out_result=0 regardless of alu_data.
REQ-026 alu_op/funct7/operand_a/operand_b are driven from registers only; they hold their last value outside EXEC.

Reset
REQ-027 rst_n low at a rising edge: state IDLE, out_valid=0, out_illegal=0, out_result=0, out_rd=0, alu_op=0, funct7=0, operand_a=0, operand_b=0.
REQ-028 Reset in EXEC or DONE discards the in-flight instruction; no out_valid is produced for it.
REQ-029 in_ready shall be 0 during reset and 1 in the first cycle after rst_n deasserts.

Configuration
REQ-030 Macro ALU_ISSUE_LUI_EN defined: LUI (0110111) is legal, operand_a=0, operand_b={instr[31:12],12'b0}, alu_op=000, funct7=0.
REQ-031 Macro undefined: LUI is illegal per REQ-023/REQ-024.

Structure
REQ-032 Package alu_issue_pkg holds opcode constants, alu_op encoding localparams, and FSM state enum.
REQ-033 One combinational sub-module alu_issue_dec: instruction + rs data -> alu_op, funct7, operands, rd, illegal.
REQ-034 The ALU itself is external; alu_issue connects through ports REQ-007..REQ-010 only.

Verification
REQ-035 ADD x3,x1,x2 (0x002081B3), rs1=5, rs2=7 -> out_valid 2 cycles after accept, out_rd=3, out_result=12, alu_op=000, funct7=0.
REQ-036 SUB x3,x1,x2 (0x402081B3), rs1=5, rs2=7 -> funct7=1, out_result=0xFFFFFFFE.
REQ-037 SRAI x5,x1,4 (0x4040D293), rs1=0x80000000 -> operand_b=4, funct7=1, out_result=0xF8000000.
REQ-038 Opcode 0x0000000F (FENCE) -> out_illegal=1, out_result=0; LUI x1,0x12345 gives 0x12345000 only with ALU_ISSUE_LUI_EN.
REQ-039 out_ready held low 5 cycles in DONE -> out_result/out_rd stable, in_ready=0; then out_ready=1 with in_valid=1 -> back-to-back accept, next out_valid 2 cycles later.
REQ-040 rst_n asserted during EXEC -> next cycle IDLE, out_valid=0; ADDI x0,x1,9 -> out_result=0.

Source files
------------

// File: rtl/alu_issue_pkg.sv
// Shared constants for the RV32I ALU issue block: opcodes, ALU op encodings, FSM states.
// Optional LUI support in the decoder is enabled with the ALU_ISSUE_LUI_EN macro.
package alu_issue_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SLL  = 3'b001;
  localparam logic [2:0] ALU_SLT  = 3'b010;
  localparam logic [2:0] ALU_SLTU = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_SRL  = 3'b101;
  localparam logic [2:0] ALU_OR   = 3'b110;
  localparam logic [2:0] ALU_AND  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic [31:0] sext12(input logic [11:0] imm);
    return {{20{imm[11]}}, imm};
  endfunction

endpackage

// File: rtl/alu_issue_dec.sv
// Combinational RV32I OP / OP-IMM decoder (plus LUI when ALU_ISSUE_LUI_EN is defined):
// produces ALU controls, operands, destination register and an illegal flag.
module alu_issue_dec
  import alu_issue_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output logic [2:0]  alu_op,
  output logic        funct7,
  output logic [31:0] operand_a,
  output logic [31:0] operand_b,
  output logic [4:0]  rd,
  output logic        illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] f7;
  logic       unused_rs1_field;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign f7     = instr[31:25];
  assign rd     = instr[11:7];
  // Register specifier bits are resolved upstream; only the data arrives here.
  assign unused_rs1_field = ^instr[19:15];

  always_comb begin
    alu_op    = ALU_ADD;
    funct7    = 1'b0;
    operand_a = 32'd0;
    operand_b = 32'd0;
    illegal   = 1'b1;
    case (opcode)
      OPC_OP: begin
        operand_a = rs1_data;
        operand_b = rs2_data;
        alu_op    = funct3;
        funct7    = instr[30];
        // The alternate funct7 only modifies ADD (->SUB) and SRL (->SRA).
        illegal   = !((f7 == F7_BASE) ||
                      ((f7 == F7_ALT) && ((funct3 == ALU_ADD) || (funct3 == ALU_SRL))));
      end
      OPC_OP_IMM: begin
        operand_a = rs1_data;
        operand_b = sext12(instr[31:20]);
        alu_op    = funct3;
        illegal   = 1'b0;
        if (funct3 == ALU_SLL) begin
          operand_b = {27'd0, instr[24:20]};
          illegal   = (f7 != F7_BASE);
        end else if (funct3 == ALU_SRL) begin
          operand_b = {27'd0, instr[24:20]};
          funct7    = instr[30];
          illegal   = !((f7 == F7_BASE) || (f7 == F7_ALT));
        end
      end
`ifdef ALU_ISSUE_LUI_EN
      OPC_LUI: begin
        operand_a = 32'd0;
        operand_b = {instr[31:12], 12'd0};
        alu_op    = ALU_ADD;
        illegal   = 1'b0;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_issue.sv
// Issue stage wrapping an external combinational ALU: accept, one EXEC cycle, hold result in DONE.
// LUI decoding is optional via ALU_ISSUE_LUI_EN (handled in alu_issue_dec).
module alu_issue
  import alu_issue_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_rs1_data,
  input  logic [31:0] in_rs2_data,
  output logic [2:0]  alu_op,
  output logic        funct7,
  output logic [31:0] operand_a,
  output logic [31:0] operand_b,
  input  logic [31:0] alu_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_rd,
  output logic [31:0] out_result,
  output logic        out_illegal,
  output state_t      dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
  // valid never waits on ready, and an offered result stays stable until it is taken.

  state_t      state, state_nxt;
  logic        accept;

  logic [2:0]  dec_alu_op;
  logic        dec_funct7;
  logic [31:0] dec_operand_a;
  logic [31:0] dec_operand_b;
  logic [4:0]  dec_rd;
  logic        dec_illegal;

  logic [2:0]  alu_op_q;
  logic        funct7_q;
  logic [31:0] operand_a_q;
  logic [31:0] operand_b_q;
  logic [4:0]  rd_q;
  logic        illegal_q;
  logic [31:0] result_q;

  alu_issue_dec u_dec (
    .instr     (in_instr),
    .rs1_data  (in_rs1_data),
    .rs2_data  (in_rs2_data),
    .alu_op    (dec_alu_op),
    .funct7    (dec_funct7),
    .operand_a (dec_operand_a),
    .operand_b (dec_operand_b),
    .rd        (dec_rd),
    .illegal   (dec_illegal)
  );

  // Gated by rst_n so nothing is taken while reset is held.
  assign in_ready = rst_n && ((state == ST_IDLE) || ((state == ST_DONE) && out_ready));
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = ST_EXEC;
      ST_EXEC: state_nxt = ST_DONE;
      ST_DONE: if (out_ready) state_nxt = accept ? ST_EXEC : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alu_op_q    <= ALU_ADD;
      funct7_q    <= 1'b0;
      operand_a_q <= 32'd0;
      operand_b_q <= 32'd0;
      rd_q        <= 5'd0;
      illegal_q   <= 1'b0;
    end else if (accept) begin
      alu_op_q    <= dec_alu_op;
      funct7_q    <= dec_funct7;
      operand_a_q <= dec_operand_a;
      operand_b_q <= dec_operand_b;
      rd_q        <= dec_rd;
      illegal_q   <= dec_illegal;
    end
  end

  // Illegal instructions and writes to x0 report a zero result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result_q <= 32'd0;
    end else if (state == ST_EXEC) begin
      result_q <= (illegal_q || (rd_q == 5'd0)) ? 32'd0 : alu_data;
    end
  end

  assign alu_op      = alu_op_q;
  assign funct7      = funct7_q;
  assign operand_a   = operand_a_q;
  assign operand_b   = operand_b_q;
  assign out_valid   = (state == ST_DONE);
  assign out_rd      = rd_q;
  assign out_result  = result_q;
  assign out_illegal = illegal_q;
  assign dbg_state   = state;

endmodule
